// File: rtl/regfile_bank_shadowed.sv
// Shadowed configuration register bank behind a valid/ready register bus.
// Software writes the shadow copy; an accepted start command (while idle)
// copies every shadow word into the active copy seen by the datapath.
// Also provides live status reads, sticky W1C event flags with a masked
// interrupt, and self-clearing command pulses.
module regfile_bank_shadowed #(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 8,
    parameter int NUM_CFG       = 32,
    parameter int NUM_STS       = 4,
    parameter int IRQ_MASK_ADDR = 'h7E,
    parameter int STICKY_ADDR   = 'h7F,
    parameter int CMD_ADDR      = 'h80
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        bus_valid,
    output logic                        bus_ready,
    input  logic                        bus_wr,
    input  logic [ADDR_W-1:0]           bus_addr,
    input  logic [DATA_W-1:0]           bus_wdata,
    output logic                        bus_rvalid,
    output logic [DATA_W-1:0]           bus_rdata,
    output logic                        bus_err,
    input  logic                        busy,
    input  logic [NUM_STS*DATA_W-1:0]   sts_in,
    input  logic [DATA_W-1:0]           hw_event,
    output logic [NUM_CFG*DATA_W-1:0]   cfg_active,
    output logic [DATA_W-1:0]           cmd_pulse,
    output logic [DATA_W-1:0]           sticky_out,
    output logic                        irq
);

    localparam int STS_BASE = 'h40;

    logic [DATA_W-1:0] shadow_reg [NUM_CFG];
    logic [DATA_W-1:0] active_reg [NUM_CFG];
    logic [DATA_W-1:0] mask_reg;
    logic [DATA_W-1:0] sticky_reg;
    logic [DATA_W-1:0] cmd_pulse_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              rvalid_reg;
    logic              err_reg;
    logic              irq_reg;

    // Address decode of the presented request
    logic accept;
    logic wr_acc;
    logic cfg_hit;
    logic sts_hit;
    logic mask_hit;
    logic sticky_hit;
    logic cmd_hit;
    logic commit;
    logic reject;

    // A new request can only be taken when no response is being presented
    assign bus_ready  = ~rvalid_reg;
    assign accept     = bus_valid & bus_ready;
    assign wr_acc     = accept & bus_wr;

    assign cfg_hit    = int'(bus_addr) < NUM_CFG;
    assign sts_hit    = (int'(bus_addr) >= STS_BASE) && (int'(bus_addr) < STS_BASE + NUM_STS);
    assign mask_hit   = int'(bus_addr) == IRQ_MASK_ADDR;
    assign sticky_hit = int'(bus_addr) == STICKY_ADDR;
    assign cmd_hit    = int'(bus_addr) == CMD_ADDR;

    // Start bit either commits the shadow (idle) or is rejected (running)
    assign commit     = wr_acc & cmd_hit & bus_wdata[0] & ~busy;
    assign reject     = wr_acc & cmd_hit & bus_wdata[0] & busy;

    assign bus_rvalid = rvalid_reg;
    assign bus_rdata  = rdata_reg;
    assign bus_err    = err_reg;
    assign cmd_pulse  = cmd_pulse_reg;
    assign sticky_out = sticky_reg;
    assign irq        = irq_reg;

    // Per-word shadow and active storage
    generate
        for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
            logic word_wr;
            assign word_wr = wr_acc && (int'(bus_addr) == gi);

            // Shadow takes bus writes; active takes the shadow on commit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= '0;
                    active_reg[gi] <= '0;
                end else begin
                    if (word_wr) begin
                        shadow_reg[gi] <= bus_wdata;
                    end
                    if (commit) begin
                        active_reg[gi] <= shadow_reg[gi];
                    end
                end
            end

            assign cfg_active[gi*DATA_W +: DATA_W] = active_reg[gi];
        end
    endgenerate

    // Read data and error for the presented request
    logic [DATA_W-1:0] rd_next;
    logic              err_next;

    // Select the response word and classify the access as legal or not
    always_comb begin
        rd_next  = '0;
        err_next = 1'b0;
        if (cfg_hit) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (int'(bus_addr) == i) begin
                    rd_next = shadow_reg[i];
                end
            end
        end else if (sts_hit) begin
            err_next = bus_wr;
            for (int i = 0; i < NUM_STS; i++) begin
                if (int'(bus_addr) == STS_BASE + i) begin
                    rd_next = sts_in[i*DATA_W +: DATA_W];
                end
            end
        end else if (mask_hit) begin
            rd_next = mask_reg;
        end else if (sticky_hit) begin
            rd_next = sticky_reg;
        end else if (cmd_hit) begin
            rd_next = '0;
        end else begin
            err_next = 1'b1;
        end
        if (bus_wr) begin
            rd_next = '0;
        end
    end

    // One-cycle response after each accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else if (accept) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_next;
            err_reg    <= err_next;
        end else begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end
    end

    // Command strobes last one cycle; a rejected start does not pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_pulse_reg <= '0;
        end else if (wr_acc && cmd_hit) begin
            cmd_pulse_reg <= {bus_wdata[DATA_W-1:1], bus_wdata[0] & ~busy};
        end else begin
            cmd_pulse_reg <= '0;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg <= '0;
        end else if (wr_acc && mask_hit) begin
            mask_reg <= bus_wdata;
        end
    end

    // Sticky flags: new events and start rejection win over a W1C clear
    logic [DATA_W-1:0] sticky_clr;
    logic [DATA_W-1:0] reject_vec;
    assign sticky_clr = (wr_acc && sticky_hit) ? bus_wdata : '0;
    assign reject_vec = {reject, {(DATA_W-1){1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= '0;
        end else begin
            sticky_reg <= (sticky_reg & ~sticky_clr) | hw_event | reject_vec;
        end
    end

    // Registered interrupt from the masked sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(sticky_reg & mask_reg);
        end
    end

endmodule

// File: doc/regfile_bank_shadowed.md
Name: regfile_bank_shadowed

Overview:
- Parametrised successor to the fixed-field layer register interface.
- Holds a generic bank of NUM_CFG configuration registers behind a valid/ready register bus.
- Double-buffers the bank: software writes a shadow copy while the datapath runs on an active copy. The shadow is committed to the active copy on an accepted start command.
- Also provides live read-only status, sticky W1C event flags with interrupt, and self-clearing command pulses. Sits between the host bus bridge and the layer controllers (conv/pool/nl/fc).

Parameters:
- DATA_W, 16, register width.
- ADDR_W, 8, bus address width.
- NUM_CFG, 32, number of config registers at addresses 0..NUM_CFG-1. Must be ≤ 0x40.
- NUM_STS, 4, number of read-only status registers at 0x40..0x40+NUM_STS-1. Must be ≤ 0x3E.
- IRQ_MASK_ADDR, 0x7E, interrupt mask register (R/W).
- STICKY_ADDR, 0x7F, sticky event register (read / write-1-to-clear).
- CMD_ADDR, 0x80, command register (write-only pulse).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- bus_valid  in  1  request valid.
- bus_ready  out  1  block can accept a request.
- bus_wr  in  1  1 = write, 0 = read.
- bus_addr  in  ADDR_W  register address.
- bus_wdata  in  DATA_W  write data.
- bus_rvalid  out  1  response valid (reads and writes).
- bus_rdata  out  DATA_W  read data; 0 on writes and errors.
- bus_err  out  1  response error, qualified by bus_rvalid.
- busy  in  1  datapath running.
- sts_in  in  NUM_STS*DATA_W  live status words; word i at [i*DATA_W +: DATA_W].
- hw_event  in  DATA_W  one-cycle event set pulses into the sticky register.
- cfg_active  out  NUM_CFG*DATA_W  active config, stable between commits.
- cmd_pulse  out  DATA_W  one-cycle command strobes.
- sticky_out  out  DATA_W  sticky register value.
- irq  out  1  OR of (sticky & mask).

Behaviour:
- Reset (rst_n low, async): all shadow, active, mask and sticky registers = 0. bus_ready=1, bus_rvalid=0, bus_rdata=0, bus_err=0, cmd_pulse=0, irq=0.
  - Reset mid-transaction drops the response.
  - Reset mid-run zeroes cfg_active immediately.
- Handshake: a transaction is accepted when bus_valid && bus_ready.
  - Next cycle: bus_rvalid=1 for exactly one cycle, with bus_rdata/bus_err. bus_ready=0 during that cycle.
  - Throughput is therefore one transaction per 2 cycles. There is no backpressure on the response.
- Register effects land on the clock edge of acceptance and are visible to a read accepted on the following transaction.
- Address map and responses:
  - 0..NUM_CFG-1: R/W shadow; reads return shadow, not active.
  - 0x40..: reads return sts_in sampled at acceptance; writes give err=1, no effect.
  - IRQ_MASK_ADDR: R/W.
  - STICKY_ADDR: read returns sticky; write clears bits where wdata=1.
  - CMD_ADDR: write only; read returns 0 with err=0.
  - Any other address: err=1, rdata=0, no effect.
- Commands (write to CMD_ADDR): cmd_pulse[k] is high for the one cycle after acceptance for each wdata[k]=1.
  - Bit 0 = start. If busy=0 at acceptance: cfg_active <= shadow (all words) on the same edge as cmd_pulse[0] rises.
  - If busy=1: cmd_pulse[0] is suppressed, no commit, and sticky[DATA_W-1] (start_rejected) is set. Other bits still pulse.
- Sticky: next = (sticky & ~clr) | hw_event | reject. Set wins over a simultaneous W1C clear of the same bit.
- irq is registered: irq = |(sticky & mask), one cycle after the sticky/mask change.
- Shadow writes during busy are legal and never disturb cfg_active.

Test Plan:
- Reset, then read addr 0x05 -> rvalid one cycle after accept, rdata=0x0000, err=0; bus_ready low on the rvalid cycle.
- Write 0x1234 to addr 3 (busy=0); check cfg_active word 3 = 0. Write CMD 0x0001 -> cfg_active word 3 = 0x1234 and cmd_pulse=0x0001 for exactly 1 cycle.
- busy=1: write 0xBEEF to addr 3, then CMD 0x0003 -> cfg_active word 3 stays 0x1234, cmd_pulse=0x0002, sticky=0x8000.
- Mask=0x0001; hw_event=0x0001 pulse -> sticky=0x0001, irq=1 next cycle. W1C 0x0001 on the same cycle as another hw_event -> sticky stays 0x0001.
- Write to 0x41 and read 0x90 -> err=1 for both, rdata=0. Read 0x41 with sts_in word 1=0x00A5 -> rdata=0x00A5, err=0.
- Assert rst_n low while rvalid is pending and busy=1 -> all outputs zero immediately, bus_ready=1 after release.
